// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
//   Multicycle RV32I-subset core (lw, sw, add, sub, and, or, slt, addi, andi,
//   ori, slti, beq, jal, lui). One ALU is time-shared across states, and a
//   single req/ready port serves instruction fetch and data accesses.
//
//   Parameters: RESET_PC (PC after reset), NREGS (16 or 32 registers).
//   Optional feature: define RVMC_BRANCH_EXT_EN to add bne/blt/bge.
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     mem_req/mem_we    access request / write strobe
//     mem_addr/wdata    byte address / store data (held during wait states)
//     mem_rdata/ready   read data / access completion
//     retired           pulse in the final cycle of each instruction
//     illegal           high while halted on an unsupported instruction
//
//   state      | meaning
//   FETCH      | read instruction at PC, PC <= PC+4
//   DECODE     | branch/jump target into ALUOut, dispatch
//   MEMADR     | effective address for lw/sw
//   MEMREAD    | data read
//   MEMWB      | write loaded data to rd
//   MEMWRITE   | data write
//   EXECR      | register-register ALU op
//   EXECI      | register-immediate ALU op
//   LUI        | upper immediate
//   ALUWB      | write ALUOut to rd
//   BRANCH     | conditional PC update
//   JAL        | PC <= target, link value into ALUOut
//   HALT       | stopped on illegal instruction until reset
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retired,
    output logic        illegal
);

    localparam int RA = (NREGS == 16) ? 4 : 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_HALT
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] data_q, data_d;
    logic [31:0] regs_q [NREGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_v, rs2_v;
    logic        legal, use_rs1, use_rs2, use_rd, reg_ok, br_take;
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_e     alu_op, alu_fn;
    logic        req_c, we_c, ret_c, rf_we;
    logic [31:0] addr_c, rf_wd;

    assign opcode = instr_q[6:0];
    assign rd_a   = instr_q[11:7];
    assign f3     = instr_q[14:12];
    assign rs1_a  = instr_q[19:15];
    assign rs2_a  = instr_q[24:20];
    assign f7     = instr_q[31:25];

    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
    assign imm_u = {instr_q[31:12], 12'b0};

    assign rs1_v = (rs1_a == 5'd0) ? 32'd0 : regs_q[rs1_a[RA-1:0]];
    assign rs2_v = (rs2_a == 5'd0) ? 32'd0 : regs_q[rs2_a[RA-1:0]];

    // Decode legality; the use_* flags limit the NREGS=16 index check to
    // fields the format actually carries (lui/jal reuse those bits as imm).
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OP_LOAD:  begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rd = 1'b1; end
            OP_STORE: begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_REG: begin
                legal = ((f7 == 7'b0000000) && (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111))
                     || ((f7 == 7'b0100000) && (f3 == 3'b000));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OP_IMM: begin
                legal = (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_LUI:   begin legal = 1'b1; use_rd = 1'b1; end
            OP_JAL:   begin legal = 1'b1; use_rd = 1'b1; end
            OP_BRANCH: begin
`ifdef RVMC_BRANCH_EXT_EN
                legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
`else
                legal = (f3 == 3'b000);
`endif
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign reg_ok = (NREGS != 16) ||
                    !((use_rs1 && rs1_a[4]) || (use_rs2 && rs2_a[4]) || (use_rd && rd_a[4]));

    always_comb begin
        br_take = (rs1_v == rs2_v);
`ifdef RVMC_BRANCH_EXT_EN
        case (f3)
            3'b001:  br_take = (rs1_v != rs2_v);
            3'b100:  br_take = ($signed(rs1_v) <  $signed(rs2_v));
            3'b101:  br_take = ($signed(rs1_v) >= $signed(rs2_v));
            default: br_take = (rs1_v == rs2_v);
        endcase
`endif
    end

    // Operand steering for the single shared ALU.
    always_comb begin
        case (f3)
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ((state_q == S_EXECR) && f7[5]) ? ALU_SUB : ALU_ADD;
        endcase
        alu_a  = pc_q;
        alu_b  = 32'd4;
        alu_op = ALU_ADD;
        case (state_q)
            S_DECODE: begin alu_a = old_pc_q; alu_b = (opcode == OP_JAL) ? imm_j : imm_b; end
            S_MEMADR: begin alu_a = rs1_v; alu_b = (opcode == OP_STORE) ? imm_s : imm_i; end
            S_EXECR:  begin alu_a = rs1_v; alu_b = rs2_v; alu_op = alu_fn; end
            S_EXECI:  begin alu_a = rs1_v; alu_b = imm_i; alu_op = alu_fn; end
            S_LUI:    begin alu_a = 32'd0; alu_b = imm_u; end
            S_JAL:    alu_a = old_pc_q;
            default:  ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        old_pc_d  = old_pc_q;
        instr_d   = instr_q;
        alu_out_d = alu_out_q;
        data_d    = data_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = pc_q;
        ret_c     = 1'b0;
        rf_we     = 1'b0;
        rf_wd     = alu_out_q;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    instr_d  = mem_rdata;
                    old_pc_d = pc_q;
                    pc_d     = alu_y;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_out_d = alu_y;
                if (!legal || !reg_ok) begin
                    state_d = S_HALT;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_REG:            state_d = S_EXECR;
                        OP_IMM:            state_d = S_EXECI;
                        OP_LUI:            state_d = S_LUI;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        default:           state_d = S_HALT;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_out_d = alu_y;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c  = 1'b1;
                addr_c = alu_out_q;
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we   = 1'b1;
                rf_wd   = data_q;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                req_c  = 1'b1;
                we_c   = 1'b1;
                addr_c = alu_out_q;
                if (mem_ready) begin
                    ret_c   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR, S_EXECI, S_LUI: begin
                alu_out_d = alu_y;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                if (br_take) pc_d = alu_out_q;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_d      = alu_out_q;
                alu_out_d = alu_y;
                state_d   = S_ALUWB;
            end
            S_HALT:  ;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        old_pc_q  <= old_pc_d;
        instr_q   <= instr_d;
        alu_out_q <= alu_out_d;
        data_q    <= data_d;
    end

    always_ff @(posedge clk) begin
        if (rf_we && (rd_a != 5'd0)) regs_q[rd_a[RA-1:0]] <= rf_wd;
    end

    // Reset gates the handshake outputs directly so an in-flight access
    // drops in the same cycle reset asserts.
    assign mem_req   = req_c & ~reset;
    assign mem_we    = we_c & ~reset;
    assign retired   = ret_c & ~reset;
    assign mem_addr  = addr_c;
    assign mem_wdata = rs2_v;
    assign illegal   = (state_q == S_HALT);

endmodule

// File: tb/tb_riscv_multicycle_core.sv
module tb_riscv_multicycle_core;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LDO = 7'b0000011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, retired, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req16, mem_we16, retired16, illegal16;
    logic [31:0] mem_addr16, mem_wdata16;
    logic [31:0] rdata16 = 32'd0;

    always #5 clk = ~clk;

    riscv_multicycle_core #(.RESET_PC(32'h0000_0100), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retired(retired), .illegal(illegal)
    );

    riscv_multicycle_core #(.RESET_PC(32'h0000_0100), .NREGS(16)) dut16 (
        .clk(clk), .reset(reset),
        .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
        .mem_rdata(rdata16), .mem_ready(1'b1),
        .retired(retired16), .illegal(illegal16)
    );

    logic [31:0] mem [256];
    int          wait_n = 0;
    logic        ready_en = 1'b1;
    int          wcnt = 0;
    int          ret_cnt = 0;
    int          ret16_cnt = 0;
    int          wr_n = 0;
    logic [31:0] wlog_a [64];
    logic [31:0] wlog_d [64];
    int          stall_chk = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_a = 32'd0;
    logic [31:0] prev_d = 32'd0;
    int          tests = 0;
    int          fails = 0;
    int          pp;
    int          ret_at [200];

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = ready_en && (wcnt >= wait_n);

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            wcnt <= 0;
            if (mem_we && wr_n < 64) begin
                wlog_a[wr_n] <= mem_addr;
                wlog_d[wr_n] <= mem_wdata;
                wr_n <= wr_n + 1;
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
        if (retired)   ret_cnt   <= ret_cnt + 1;
        if (retired16) ret16_cnt <= ret16_cnt + 1;
    end

    // Request attributes must hold while a request waits for ready.
    always @(negedge clk) begin
        if (prev_stall && mem_req) begin
            stall_chk <= stall_chk + 1;
            if (mem_addr !== prev_a || mem_we !== prev_we || (mem_we && mem_wdata !== prev_d))
                stall_bad <= stall_bad + 1;
        end
        prev_stall <= mem_req && !mem_ready && !reset;
        prev_a     <= mem_addr;
        prev_we    <= mem_we;
        prev_d     <= mem_wdata;
    end

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] ins);
        mem[pp] = ins;
        pp++;
    endtask

    // Enter reset with a cleared memory; program is loaded afterwards.
    task automatic start(input int wn);
        @(negedge clk);
        reset    = 1'b1;
        wait_n   = wn;
        ready_en = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        pp = 64;
    endtask

    task automatic run_prog(input int limit, output int first_wr, output int halt_k);
        first_wr = -1;
        halt_k   = -1;
        for (int k = 0; k < limit; k++) begin
            if (k < 200) ret_at[k] = ret_cnt;
            if (first_wr < 0 && mem_req && mem_we) first_wr = k;
            if (illegal) begin
                halt_k = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int fw, hk, ret0, wr0, reqs, r0;
        bit found;
        logic [31:0] exp_a [10];
        logic [31:0] exp_d [10];

        rdata16 = r_t(7'd0, 5'd2, 5'd1, 3'b000, 5'd20);

        // ---------------- zero-wait program ----------------
        start(0);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_retired", {31'd0, retired}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        put(i_t(12'd5, 5'd0, 3'b000, 5'd2, OPI));
        put(i_t(12'd12, 5'd0, 3'b000, 5'd3, OPI));
        put(r_t(7'd0, 5'd3, 5'd2, 3'b000, 5'd4));
        put(s_t(12'd100, 5'd4, 5'd0));
        ret0 = ret_cnt; wr0 = wr_n;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);
        run_prog(60, fw, hk);
        chk("zw_ret_c15", ret_at[15] - ret0, 32'd3);
        chk("zw_ret_c16", ret_at[16] - ret0, 32'd4);
        chk("zw_write_cyc", fw, 32'd15);
        chk("zw_halt_cyc", hk, 32'd18);
        chk("zw_nwrites", wr_n - wr0, 32'd1);
        chk("zw_waddr", wlog_a[wr0], 32'd100);
        chk("zw_wdata", wlog_d[wr0], 32'd17);
        chk("n16_illegal", {31'd0, illegal16}, 32'd1);
        chk("n16_no_retire", ret16_cnt, 32'd0);
        chk("n16_no_req", {31'd0, mem_req16}, 32'd0);

        // ---------------- same program, 2 wait states per request ----------------
        start(2);
        put(i_t(12'd5, 5'd0, 3'b000, 5'd2, OPI));
        put(i_t(12'd12, 5'd0, 3'b000, 5'd3, OPI));
        put(r_t(7'd0, 5'd3, 5'd2, 3'b000, 5'd4));
        put(s_t(12'd100, 5'd4, 5'd0));
        ret0 = ret_cnt; wr0 = wr_n;
        reset = 1'b0;
        #1;
        run_prog(100, fw, hk);
        chk("ws_write_cyc", fw, 32'd23);
        chk("ws_halt_cyc", hk, 32'd30);
        chk("ws_retired", ret_cnt - ret0, 32'd4);
        chk("ws_waddr", wlog_a[wr0], 32'd100);
        chk("ws_wdata", wlog_d[wr0], 32'd17);
        chk("ws_stall_seen", {31'd0, stall_chk > 0}, 32'd1);
        chk("ws_stall_stable", stall_bad, 32'd0);

        // ---------------- lw / jal / lui / beq / ALU mix ----------------
        start(0);
        mem[24] = 32'hDEAD_BEEF;
        put(i_t(12'd96, 5'd0, 3'b010, 5'd5, LDO));          // 100 lw x5,96(x0)
        put(j_t(21'd8, 5'd1));                               // 104 jal x1,+8
        put(32'd0);                                          // 108 skipped
        put(u_t(20'h12345, 5'd6));                           // 10C lui x6
        put(i_t(12'd3, 5'd0, 3'b000, 5'd11, OPI));           // 110 addi x11,x0,3
        put(b_t(13'd8, 5'd11, 5'd11, 3'b000));               // 114 beq taken
        put(32'd0);                                          // 118 skipped
        put(b_t(13'd8, 5'd0, 5'd11, 3'b000));                // 11C beq not taken
        put(s_t(12'd200, 5'd5, 5'd0));
        put(s_t(12'd204, 5'd1, 5'd0));
        put(s_t(12'd208, 5'd6, 5'd0));
        put(r_t(7'b0100000, 5'd11, 5'd0, 3'b000, 5'd12));    // sub x12 = -3
        put(r_t(7'd0, 5'd11, 5'd12, 3'b010, 5'd13));         // slt x13 = 1
        put(i_t(12'hFFB, 5'd11, 3'b010, 5'd14, OPI));        // slti x14 = (3 < -5) = 0
        put(i_t(12'h0F0, 5'd12, 3'b111, 5'd15, OPI));        // andi x15 = 0xF0
        put(i_t(12'h100, 5'd11, 3'b110, 5'd16, OPI));        // ori x16 = 0x103
        put(r_t(7'd0, 5'd11, 5'd12, 3'b111, 5'd17));         // and x17 = 1
        put(r_t(7'd0, 5'd11, 5'd12, 3'b110, 5'd18));         // or x18 = -1
        for (int r = 12; r <= 18; r++) put(s_t(12'(212 + 4 * (r - 12)), 5'(r), 5'd0));
        exp_a = '{32'd200, 32'd204, 32'd208, 32'd212, 32'd216, 32'd220, 32'd224, 32'd228, 32'd232, 32'd236};
        exp_d = '{32'hDEAD_BEEF, 32'h108, 32'h1234_5000, 32'hFFFF_FFFD, 32'd1, 32'd0,
                  32'hF0, 32'h103, 32'd1, 32'hFFFF_FFFF};
        ret0 = ret_cnt; wr0 = wr_n;
        reset = 1'b0;
        #1;
        run_prog(200, fw, hk);
        chk("mix_halted", {31'd0, hk >= 0}, 32'd1);
        chk("mix_retired", ret_cnt - ret0, 32'd23);
        chk("mix_nwrites", wr_n - wr0, 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("mix_waddr%0d", i), wlog_a[wr0 + i], exp_a[i]);
            chk($sformatf("mix_wdata%0d", i), wlog_d[wr0 + i], exp_d[i]);
        end

        // ---------------- illegal opcode ----------------
        start(0);
        put(32'h0000_0073);
        ret0 = ret_cnt;
        reset = 1'b0;
        #1;
        run_prog(20, fw, hk);
        chk("ill_halt_cyc", hk, 32'd2);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (!illegal) reqs++;
        end
        chk("ill_no_req_sticky", reqs, 32'd0);
        chk("ill_no_retire", ret_cnt - ret0, 32'd0);
        start(0);
        #1;
        chk("ill_cleared", {31'd0, illegal}, 32'd0);
        put(32'h0000_0073);
        reset = 1'b0;
        #1;
        chk("ill_restart_req", {31'd0, mem_req}, 32'd1);
        chk("ill_restart_addr", mem_addr, 32'h100);

        // ---------------- extended branches ----------------
        start(0);
        put(i_t(12'hFFF, 5'd0, 3'b000, 5'd7, OPI));   // 100 x7 = -1
        put(i_t(12'd1, 5'd0, 3'b000, 5'd8, OPI));     // 104 x8 = 1
        put(b_t(13'd8, 5'd8, 5'd7, 3'b100));          // 108 blt x7,x8,+8
        put(32'd0);                                   // 10C
        put(b_t(13'd8, 5'd8, 5'd7, 3'b101));          // 110 bge x7,x8,+8
        put(s_t(12'd240, 5'd7, 5'd0));                // 114 sw x7,240
        ret0 = ret_cnt; wr0 = wr_n;
        reset = 1'b0;
        #1;
        run_prog(60, fw, hk);
`ifdef RVMC_BRANCH_EXT_EN
        chk("br_halt_cyc", hk, 32'd20);
        chk("br_retired", ret_cnt - ret0, 32'd5);
        chk("br_nwrites", wr_n - wr0, 32'd1);
        chk("br_waddr", wlog_a[wr0], 32'd240);
        chk("br_wdata", wlog_d[wr0], 32'hFFFF_FFFF);
`else
        chk("br_halt_cyc", hk, 32'd10);
        chk("br_retired", ret_cnt - ret0, 32'd2);
        chk("br_nwrites", wr_n - wr0, 32'd0);
`endif

        // ---------------- reset during a stalled lw ----------------
        start(0);
        mem[24] = 32'h5555_5555;
        put(i_t(12'd77, 5'd0, 3'b000, 5'd9, OPI));
        put(i_t(12'd96, 5'd0, 3'b010, 5'd9, LDO));
        reset = 1'b0;
        #1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && !mem_we && mem_addr == 32'd96) begin
                ready_en = 1'b0;
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rl_found_read", {31'd0, found}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rl_stalled", {31'd0, mem_req}, 32'd1);
        r0 = ret_cnt; wr0 = wr_n;
        reset = 1'b1;
        #1;
        chk("rl_req_drop", {31'd0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rl_no_retire", ret_cnt - r0, 32'd0);
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        pp = 64;
        put(s_t(12'd204, 5'd9, 5'd0));
        ready_en = 1'b1;
        reset = 1'b0;
        #1;
        chk("rl_restart_addr", mem_addr, 32'h100);
        run_prog(40, fw, hk);
        chk("rl_nwrites", wr_n - wr0, 32'd1);
        chk("rl_rd_unchanged", wlog_d[wr0], 32'd77);
        chk("rl_waddr", wlog_a[wr0], 32'd204);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
